// File: rtl/vga_compositor.sv
// Pixel compositor: layer priority/transparency, battle-box border, 12-bit VGA expansion,
// sync alignment and monster hit-flash FSM. Optional brightness fade-in under COMPOSITOR_FADE_EN.
module vga_compositor #(
  parameter int          SYNC_DLY     = 1,
  parameter int          FLASH_FRAMES = 24,
  parameter int          BLINK_LOG2   = 2,
  parameter int          BOX_X0       = 32,
  parameter int          BOX_Y0       = 240,
  parameter int          BOX_X1       = 607,
  parameter int          BOX_Y1       = 463,
  parameter logic [11:0] BG_RGB       = 12'h000
) (
  input  logic       Pclk,
  input  logic       rst_n,
  input  logic [9:0] xx,
  input  logic [9:0] yy,
  input  logic       aactive,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       M1SpriteOn,
  input  logic [7:0] M1dataout,
  input  logic       HSpriteOn,
  input  logic [7:0] Hdataout,
  input  logic       hit,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       flashing
);

  typedef enum logic {IDLE, FLASH} state_t;

  localparam logic [9:0] BX0     = 10'(BOX_X0);
  localparam logic [9:0] BY0     = 10'(BOX_Y0);
  localparam logic [9:0] BX1     = 10'(BOX_X1);
  localparam logic [9:0] BY1     = 10'(BOX_Y1);
  localparam logic [7:0] FC_LAST = 8'(FLASH_FRAMES - 1);
  // delay-line word is {active, hsync, vsync, box}; syncs idle high
  localparam logic [3:0] DL_RST  = 4'b0110;

  function automatic logic [11:0] expand(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

  logic box, tick;
  always_comb begin
    box = (xx >= BX0) && (xx <= BX1) && (yy >= BY0) && (yy <= BY1) &&
          ((xx <= BX0 + 10'd2) || (xx + 10'd2 >= BX1) ||
           (yy <= BY0 + 10'd2) || (yy + 10'd2 >= BY1));
    tick = (xx == 10'd639) && (yy == 10'd479);
  end

  logic [SYNC_DLY-1:0][3:0] dl;
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      dl <= {SYNC_DLY{DL_RST}};
    end else begin
      dl[0] <= {aactive, hsync_in, vsync_in, box};
      for (int i = 1; i < SYNC_DLY; i++) dl[i] <= dl[i-1];
    end
  end

  logic d_active, d_hs, d_vs, d_box;
  assign {d_active, d_hs, d_vs, d_box} = dl[SYNC_DLY-1];

  state_t     state, state_nxt;
  logic [7:0] fc, fc_nxt;
  logic       mon_vis;

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fc    <= 8'd0;
    end else begin
      state <= state_nxt;
      fc    <= fc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fc_nxt    = fc;
    mon_vis   = 1'b1;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nxt = FLASH;
          fc_nxt    = 8'd0;
        end
      end
      FLASH: begin
        mon_vis = ~fc[BLINK_LOG2];
        // a hit always restarts the blink sequence, even on a frame tick
        if (hit) begin
          fc_nxt = 8'd0;
        end else if (tick) begin
          if (fc == FC_LAST) begin
            state_nxt = IDLE;
            fc_nxt    = 8'd0;
          end else begin
            fc_nxt = fc + 8'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        fc_nxt    = 8'd0;
      end
    endcase
  end

  assign flashing = (state == FLASH);

  logic        h_on, m_on;
  logic [11:0] rgb, out_rgb;
  always_comb begin
    h_on = HSpriteOn && (Hdataout != 8'h00);
    m_on = M1SpriteOn && (M1dataout != 8'h00) && mon_vis;
    if (h_on)       rgb = expand(Hdataout);
    else if (m_on)  rgb = expand(M1dataout);
    else if (d_box) rgb = 12'hFFF;
    else            rgb = BG_RGB;
  end

`ifdef COMPOSITOR_FADE_EN
  logic [3:0] level;
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n)                      level <= 4'd0;
    else if (tick && level != 4'hF)  level <= level + 4'd1;
  end

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] lv);
    logic [7:0] p;
    p = {4'd0, c} * ({4'd0, lv} + 8'd1);
    return p[7:4];
  endfunction

  assign out_rgb = {scale(rgb[11:8], level), scale(rgb[7:4], level), scale(rgb[3:0], level)};
`else
  assign out_rgb = rgb;
`endif

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      red   <= d_active ? out_rgb[11:8] : 4'd0;
      green <= d_active ? out_rgb[7:4]  : 4'd0;
      blue  <= d_active ? out_rgb[3:0]  : 4'd0;
      hsync <= d_hs;
      vsync <= d_vs;
    end
  end

endmodule
